// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline register with valid/ready handshake and a one-entry skid buffer.
// Carries ALU result, destination register and M/WB control; exposes a qualified forwarding enable.
module ex_mem_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned M_W    = 2,
  parameter int unsigned WB_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [RA_W-1:0]   in_rd_addr,
  input  logic [M_W-1:0]    in_m,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [RA_W-1:0]   out_rd_addr,
  output logic [M_W-1:0]    out_m,
  output logic [WB_W-1:0]   out_wb,
  output logic              fwd_wr_en
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic              r_in_ready;

  logic [DATA_W-1:0] r_main_alu;
  logic [RA_W-1:0]   r_main_rd;
  logic [M_W-1:0]    r_main_m;
  logic [WB_W-1:0]   r_main_wb;

  logic [DATA_W-1:0] r_skid_alu;
  logic [RA_W-1:0]   r_skid_rd;
  logic [M_W-1:0]    r_skid_m;
  logic [WB_W-1:0]   r_skid_wb;

  logic w_accept;
  logic w_main_free;
  logic w_main_from_skid;
  logic w_main_from_in;
  logic w_skid_load;
  logic w_main_valid_d;
  logic w_skid_valid_d;

  always_comb begin
    w_accept    = in_valid & r_in_ready;
    // Main can take a new entry when it is empty or being drained this cycle.
    w_main_free = ~r_main_valid | out_ready;

    w_main_from_skid = ~flush & w_main_free & r_skid_valid;
    w_main_from_in   = ~flush & w_main_free & ~r_skid_valid & w_accept;
    w_skid_load      = ~flush & ~w_main_free & w_accept;

    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (w_main_free) begin
      w_main_valid_d = r_skid_valid | w_accept;
      w_skid_valid_d = 1'b0;
    end else begin
      w_main_valid_d = 1'b1;
      w_skid_valid_d = r_skid_valid | w_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_skid_valid <= w_skid_valid_d;
      r_in_ready   <= ~w_skid_valid_d;
    end
  end

  // Skid is written before main is refilled from it, so the older entry always leaves first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_alu <= '0;
      r_main_rd  <= '0;
      r_main_m   <= '0;
      r_main_wb  <= '0;
    end else if (w_main_from_skid) begin
      r_main_alu <= r_skid_alu;
      r_main_rd  <= r_skid_rd;
      r_main_m   <= r_skid_m;
      r_main_wb  <= r_skid_wb;
    end else if (w_main_from_in) begin
      r_main_alu <= in_alu_result;
      r_main_rd  <= in_rd_addr;
      r_main_m   <= in_m;
      r_main_wb  <= in_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_alu <= '0;
      r_skid_rd  <= '0;
      r_skid_m   <= '0;
      r_skid_wb  <= '0;
    end else if (w_skid_load) begin
      r_skid_alu <= in_alu_result;
      r_skid_rd  <= in_rd_addr;
      r_skid_m   <= in_m;
      r_skid_wb  <= in_wb;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_valid;
  assign out_alu_result = r_main_alu;
  assign out_rd_addr    = r_main_rd;
  assign out_m          = r_main_m;
  assign out_wb         = r_main_wb;

  // Only the main (older) entry may forward; the skid entry is younger.
  assign fwd_wr_en = r_main_valid & r_main_wb[0] & (r_main_rd != '0);

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Scoreboard bench for ex_mem_stage_buf: stimulus queues expected bundles on accept,
// a negedge monitor checks occupancy, handshake and data against an in-order queue model.
module tb_ex_mem_stage_buf;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic [1:0]  m;
    logic [0:0]  wb;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_m;
  logic [0:0]  in_wb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_result;
  logic [4:0]  out_rd_addr;
  logic [1:0]  out_m;
  logic [0:0]  out_wb;
  logic        fwd_wr_en;

  bundle_t exp_q[$];
  int      pend   = 0;
  int      checks = 0;
  int      errors = 0;

  ex_mem_stage_buf dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_rd_addr     (in_rd_addr),
    .in_m           (in_m),
    .in_wb          (in_wb),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_rd_addr    (out_rd_addr),
    .out_m          (out_m),
    .out_wb         (out_wb),
    .fwd_wr_en      (fwd_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; an input that will be accepted at the next edge is queued.
  task automatic apply(input logic v, input logic [31:0] d, input logic [4:0] rd,
                       input logic [1:0] m, input logic wb, input logic ordy, input logic fl);
    in_valid      = v;
    in_alu_result = d;
    in_rd_addr    = rd;
    in_m          = m;
    in_wb         = wb;
    out_ready     = ordy;
    flush         = fl;
    pend          = 0;
    if (v && in_ready && rst_n) begin
      exp_q.push_back('{d: d, rd: rd, m: m, wb: wb});
      pend = 1;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] rd,
                      input logic [1:0] m, input logic wb, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    apply(v, d, rd, m, wb, ordy, fl);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 5'd0, 2'd0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: model holds entries accepted at earlier edges; the newest push is still pending.
  always @(negedge clk) begin
    int      held;
    bundle_t e;
    if (rst_n) begin
      held = exp_q.size() - pend;
      chk("out_valid", 64'(out_valid), 64'(held > 0));
      chk("in_ready", 64'(in_ready), 64'(held < 2));
      if (held > 0) begin
        e = exp_q[0];
        chk("out_alu_result", 64'(out_alu_result), 64'(e.d));
        chk("out_rd_addr", 64'(out_rd_addr), 64'(e.rd));
        chk("out_m", 64'(out_m), 64'(e.m));
        chk("out_wb", 64'(out_wb), 64'(e.wb));
        chk("fwd_wr_en", 64'(fwd_wr_en), 64'(e.wb[0] && e.rd != 5'd0));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("fwd_wr_en_idle", 64'(fwd_wr_en), 64'(0));
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b1;
    in_alu_result = 32'hDEAD_BEEF;
    in_rd_addr    = 5'd9;
    in_m          = 2'd3;
    in_wb         = 1'b1;
    out_ready     = 1'b0;

    // Reset held with in_valid asserted.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_alu", 64'(out_alu_result), 64'(0));
    chk("rst_fwd", 64'(fwd_wr_en), 64'(0));

    // First accept happens on the first edge after release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 32'h5, 5'd1, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Streaming.
    step(1'b1, 32'h11, 5'd1, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h22, 5'd2, 2'd1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h33, 5'd3, 2'd2, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall into skid, then release in order.
    step(1'b1, 32'hA, 5'd3, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'hB, 5'd4, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hBAD, 5'd5, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with main and skid full.
    step(1'b1, 32'h1A, 5'd6, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1B, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 32'hC, 5'd8, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush on a cycle where an input is accepted and main is popped.
    step(1'b1, 32'h2A, 5'd1, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h2B, 5'd2, 2'd0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Forwarding qualification, held in main while stalled.
    step(1'b1, 32'h70, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 32'h71, 5'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 32'h72, 5'd7, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle with both entries full.
    step(1'b1, 32'h3A, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h3B, 5'd4, 2'd2, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    chk("async_rst_out_alu", 64'(out_alu_result), 64'(0));
    chk("async_rst_fwd", 64'(fwd_wr_en), 64'(0));
    exp_q.delete();
    pend = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 32'h44, 5'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 99) < 60, $urandom,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 2'($urandom), 1'($urandom),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) == 0);
    end

    repeat (4) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
